// File: rtl/compare_scheduler.sv
// Compare-target scheduler: a queue of {level, target} entries whose head is matched against the
// running count. On a qualified match it drives the output level, pulses fire and pops the entry.
// Optional sticky push-while-full flag: define COMPARE_SCHEDULER_OVERRUN_EN.
//
// Handshake: a push happens on a clock edge where wr_valid & wr_ready are both high.
// wr_ready = ena & ~full and does not depend on wr_valid or on a pop in the same cycle.
module compare_scheduler #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     ena,
    input  logic                     srst,
    input  logic [WIDTH-1:0]         cnt,
    input  logic                     cnt_sync,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [WIDTH-1:0]         wr_target,
    input  logic                     wr_level,
    output logic [WIDTH-1:0]         head_target,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     empty,
    output logic                     out,
    output logic                     fire,
    output logic                     overrun,
    input  logic                     ovr_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH:0]   mem_q [DEPTH];
    logic [WIDTH:0]   mem_d [DEPTH];
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             out_q, out_d, fire_q, fire_d;
    logic             full, is_empty, hit, push;
    logic [WIDTH:0]   head_entry;

    assign full        = (count_q == CW'(DEPTH));
    assign is_empty    = (count_q == '0);
    assign head_entry  = mem_q[rd_q];
    assign wr_ready    = ena & ~full;
    assign push        = wr_valid & wr_ready;
    // A freshly pushed entry only becomes visible here after its write edge, so it cannot hit early.
    assign hit         = ena & cnt_sync & ~is_empty & (cnt == head_entry[WIDTH-1:0]);

    assign head_target = is_empty ? '0 : head_entry[WIDTH-1:0];
    assign pending     = count_q;
    assign empty       = is_empty;
    assign out         = out_q;
    assign fire        = fire_q;

    always_comb begin
        mem_d   = mem_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        out_d   = out_q;
        fire_d  = 1'b0;
        if (srst) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
            out_d   = 1'b0;
        end else if (ena) begin
            fire_d = hit;
            if (hit) begin
                out_d = head_entry[WIDTH];
                rd_d  = rd_q + AW'(1);
            end
            if (push) begin
                mem_d[wr_q] = {wr_level, wr_target};
                wr_d        = wr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(hit);
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            out_q   <= 1'b0;
            fire_q  <= 1'b0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            out_q   <= out_d;
            fire_q  <= fire_d;
        end
    end

    // Payload storage needs no reset: entries are only read while count says they are valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef COMPARE_SCHEDULER_OVERRUN_EN
    logic ovr_q, ovr_d;

    always_comb begin
        ovr_d = ovr_q;
        if (srst) begin
            ovr_d = 1'b0;
        end else if (ena) begin
            if (wr_valid && full) begin
                ovr_d = 1'b1;
            end else if (ovr_clr) begin
                ovr_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign overrun = ovr_q;
`else
    logic unused_ovr_clr;
    assign unused_ovr_clr = ovr_clr;
    assign overrun        = 1'b0;
`endif

endmodule

// File: tb/tb_compare_scheduler.sv
// Self-checking bench for compare_scheduler: hand-written vector table, a queue-based
// reference model checked every cycle, and a scoreboard of expected fire levels.
module tb_compare_scheduler;
    localparam int W = 24;
    localparam int D = 4;

    logic           clk = 1'b0;
    logic           arst, ena, srst, cnt_sync, wr_valid, wr_level, ovr_clr;
    logic [W-1:0]   cnt, wr_target;
    logic           wr_ready, empty, out, fire, overrun;
    logic [W-1:0]   head_target;
    logic [2:0]     pending;

    compare_scheduler #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .arst(arst), .ena(ena), .srst(srst), .cnt(cnt), .cnt_sync(cnt_sync),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_target(wr_target), .wr_level(wr_level),
        .head_target(head_target), .pending(pending), .empty(empty), .out(out),
        .fire(fire), .overrun(overrun), .ovr_clr(ovr_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: plain queue of {level, target}
    logic [W:0]   mq[$];
    logic         m_out = 1'b0, m_fire = 1'b0, m_ovr = 1'b0;
    // scoreboard: output levels expected on each fire pulse, in order
    logic [0:0]   exp_q[$];

    typedef struct {
        logic         e;
        logic         sy;
        logic [W-1:0] c;
        logic         wv;
        logic [W-1:0] wt;
        logic         wl;
        logic         x_out;
        logic         x_fire;
        logic [2:0]   x_pend;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_out  = 1'b0;
        m_fire = 1'b0;
        m_ovr  = 1'b0;
    endtask

    // One clock cycle: drive, check combinational outputs, advance model, check registered outputs.
    task automatic cyc(input logic e, input logic sy, input logic [W-1:0] c, input logic wv,
                       input logic [W-1:0] wt, input logic wl, input logic oc, input logic sr);
        logic m_full, m_ready, m_hit;
        logic [0:0] lvl;
        ena = e; cnt_sync = sy; cnt = c; wr_valid = wv; wr_target = wt; wr_level = wl;
        ovr_clr = oc; srst = sr;
        #1;
        m_full  = (mq.size() == D);
        m_ready = e && !m_full;
        m_hit   = e && sy && (mq.size() != 0) && (c == mq[0][W-1:0]);
        chk("wr_ready", {31'd0, wr_ready}, {31'd0, m_ready});
        chk("head_pre", {8'd0, head_target}, (mq.size() != 0) ? {8'd0, mq[0][W-1:0]} : 32'd0);
        if (sr) begin
            mq.delete();
            m_out = 1'b0; m_fire = 1'b0; m_ovr = 1'b0;
        end else if (e) begin
            m_fire = m_hit;
            if (m_hit) begin
                m_out = mq[0][W];
                exp_q.push_back(mq[0][W]);
                void'(mq.pop_front());
            end
            if (wv && m_ready) mq.push_back({wl, wt});
`ifdef COMPARE_SCHEDULER_OVERRUN_EN
            if (wv && m_full) m_ovr = 1'b1;
            else if (oc) m_ovr = 1'b0;
`endif
        end else begin
            m_fire = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("out", {31'd0, out}, {31'd0, m_out});
        chk("fire", {31'd0, fire}, {31'd0, m_fire});
        chk("pending", {29'd0, pending}, mq.size());
        chk("empty", {31'd0, empty}, {31'd0, mq.size() == 0});
        chk("head", {8'd0, head_target}, (mq.size() != 0) ? {8'd0, mq[0][W-1:0]} : 32'd0);
        chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
        if (fire) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_fire", 32'd1, 32'd0);
            end else begin
                lvl = exp_q.pop_front();
                chk("fire_level", {31'd0, out}, {31'd0, lvl});
            end
        end
    endtask

    task automatic push(input logic [W-1:0] t, input logic l);
        cyc(1'b1, 1'b0, '0, 1'b1, t, l, 1'b0, 1'b0);
    endtask

    task automatic count(input logic [W-1:0] c);
        cyc(1'b1, 1'b1, c, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        vecs[0] = '{1, 1, 24'd0,   1, 24'd100, 1, 0, 0, 3'd1};
        vecs[1] = '{1, 1, 24'd99,  1, 24'd200, 0, 0, 0, 3'd2};
        vecs[2] = '{1, 0, 24'd100, 0, 24'd0,   0, 0, 0, 3'd2};
        vecs[3] = '{1, 1, 24'd101, 0, 24'd0,   0, 0, 0, 3'd2};
        vecs[4] = '{1, 1, 24'd100, 0, 24'd0,   0, 1, 1, 3'd1};
        vecs[5] = '{1, 1, 24'd150, 0, 24'd0,   0, 1, 0, 3'd1};
        vecs[6] = '{0, 1, 24'd200, 0, 24'd0,   0, 1, 0, 3'd1};
        vecs[7] = '{1, 1, 24'd200, 0, 24'd0,   0, 0, 1, 3'd0};
        vecs[8] = '{1, 1, 24'd200, 0, 24'd0,   0, 0, 0, 3'd0};

        arst = 1'b0; ena = 1'b1; srst = 1'b0; cnt = '0; cnt_sync = 1'b0;
        wr_valid = 1'b0; wr_target = '0; wr_level = 1'b0; ovr_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", {31'd0, out}, 32'd0);
        chk("rst_fire", {31'd0, fire}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_pending", {29'd0, pending}, 32'd0);
        chk("rst_head", {8'd0, head_target}, 32'd0);
        chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        arst = 1'b1;
        @(posedge clk);
        #1;

        // table vectors: push/hit basics, unqualified count, ena hold
        for (int i = 0; i < 9; i++) begin
            cyc(vecs[i].e, vecs[i].sy, vecs[i].c, vecs[i].wv, vecs[i].wt, vecs[i].wl, 1'b0, 1'b0);
            chk("vec_out", {31'd0, out}, {31'd0, vecs[i].x_out});
            chk("vec_fire", {31'd0, fire}, {31'd0, vecs[i].x_fire});
            chk("vec_pending", {29'd0, pending}, {29'd0, vecs[i].x_pend});
        end

        // counter sweep 0..255 across two targets
        push(24'd100, 1'b1);
        push(24'd200, 1'b0);
        for (int c = 0; c < 256; c++) count(24'(c));
        chk("sweep_empty", {31'd0, empty}, 32'd1);

        // push into empty queue cannot hit in its write cycle; duplicate targets hit on successive strobes
        cyc(1'b1, 1'b1, 24'd50, 1'b1, 24'd50, 1'b1, 1'b0, 1'b0);
        push(24'd50, 1'b1);
        count(24'd50);
        count(24'd50);
        count(24'd50);

        // fill, refused fifth push, overrun and its clear
        for (int k = 0; k < D; k++) push(24'd1000 + 24'(k), k[0]);
        push(24'd2000, 1'b1);
        cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        // full queue: hit and push in the same cycle, push refused
        cyc(1'b1, 1'b1, 24'd1000, 1'b1, 24'd3000, 1'b1, 1'b0, 1'b0);
        chk("full_hit_push", {29'd0, pending}, 32'd3);
        count(24'd1001);
        count(24'd1002);
        // single entry: hit and push together keep pending at 1
        cyc(1'b1, 1'b1, 24'd1003, 1'b1, 24'd1100, 1'b1, 1'b0, 1'b0);
        chk("one_hit_push", {29'd0, pending}, 32'd1);
        chk("one_new_head", {8'd0, head_target}, 32'd1100);
        count(24'd1100);

        // wrap-around targets with ena low over the second match
        push(24'hFFFFFF, 1'b1);
        push(24'h000002, 1'b0);
        count(24'hFFFFFE);
        count(24'hFFFFFF);
        cyc(1'b0, 1'b1, 24'h000000, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        count(24'h000001);
        cyc(1'b0, 1'b1, 24'h000002, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("ena_low_out", {31'd0, out}, 32'd1);
        count(24'h000002);

        // synchronous clear
        push(24'd7, 1'b1);
        push(24'd8, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        count(24'd7);

        // asynchronous reset mid-queue with pending 3 and out high
        for (int k = 0; k < 4; k++) push(24'd500 + 24'(k), 1'b1);
        count(24'd500);
        chk("pre_arst_pending", {29'd0, pending}, 32'd3);
        arst = 1'b0;
        #1;
        chk("arst_out", {31'd0, out}, 32'd0);
        chk("arst_fire", {31'd0, fire}, 32'd0);
        chk("arst_empty", {31'd0, empty}, 32'd1);
        chk("arst_pending", {29'd0, pending}, 32'd0);
        chk("arst_head", {8'd0, head_target}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        arst = 1'b1;
        count(24'd501);
        push(24'd9, 1'b1);
        count(24'd9);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
